// File: rtl/cmp_flag_unit.sv
// rtl/cmp_flag_unit.sv - multi-cycle CMP/CMN/TST/TEQ evaluator owning the NZCV flag register
//
// Processes two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first,
// and updates the {N,Z,C,V} flag register on completion when requested.
//
// Optional feature macro: CMP_COND_EN (adds cond / cond_pass condition check)
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      request valid
//   in_ready    out  1      high only in IDLE
//   op_a        in   WIDTH  first operand
//   op_b        in   WIDTH  second operand
//   mode        in   2      0=CMP(a-b) 1=CMN(a+b) 2=TST(a&b) 3=TEQ(a^b)
//   set_flags   in   1      write flags on completion
//   flag_wr     in   1      external flag write
//   flag_wdata  in   4      external flag value {N,Z,C,V}
//   flag_out    out  4      flag register {N,Z,C,V}
//   done        out  1      one-cycle completion pulse
//   busy        out  1      high in RUN
//   cond        in   4      condition code (CMP_COND_EN only)
//   cond_pass   out  1      condition holds for current flags (CMP_COND_EN only)

module cmp_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int STEPS = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             set_flags,
  input  logic             flag_wr,
  input  logic [3:0]       flag_wdata,
  output logic [3:0]       flag_out,
  output logic             done,
  output logic             busy
`ifdef CMP_COND_EN
  ,
  input  logic [3:0]       cond,
  output logic [0:0]       cond_pass
`endif
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_CMP = 2'd0,
    MODE_CMN = 2'd1,
    MODE_TST = 2'd2,
    MODE_TEQ = 2'd3
  } mode_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  mode_e             mode_q, mode_d;
  logic              setf_q, setf_d;
  logic              carry_q, carry_d;
  logic              z_q, z_d;
  logic [SW-1:0]     step_q, step_d;
  logic [3:0]        flag_q, flag_d;
  logic              done_q, done_d;

  // Datapath for the chunk currently at the bottom of the operand shifters.
  logic [CHUNK-1:0]  a_c, b_c, b_eff, r_c;
  logic [CHUNK:0]    sum;
  logic              last_step;
  logic              n_new, z_new, c_new, v_new;
  logic              a_msb, b_msb;

  always_comb begin
    a_c   = a_q[CHUNK-1:0];
    b_c   = b_q[CHUNK-1:0];
    // CMP is a + ~b + 1; the +1 enters as the initial carry set on accept.
    b_eff = (mode_q == MODE_CMP) ? ~b_c : b_c;
    sum   = {1'b0, a_c} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};

    case (mode_q)
      MODE_CMP, MODE_CMN: r_c = sum[CHUNK-1:0];
      MODE_TST:           r_c = a_c & b_c;
      default:            r_c = a_c ^ b_c;
    endcase

    last_step = (step_q == LAST_STEP);

    // Only meaningful on the last step, when the MSB chunk is at the bottom.
    a_msb = a_c[CHUNK-1];
    b_msb = b_c[CHUNK-1];
    n_new = r_c[CHUNK-1];
    z_new = z_q & (r_c == '0);

    c_new = flag_q[1];
    v_new = flag_q[0];
    case (mode_q)
      MODE_CMP: begin
        c_new = sum[CHUNK];
        v_new = (a_msb != b_msb) && (n_new != a_msb);
      end
      MODE_CMN: begin
        c_new = sum[CHUNK];
        v_new = (a_msb == b_msb) && (n_new != a_msb);
      end
      default: begin
        c_new = flag_q[1];
        v_new = flag_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    setf_d  = setf_q;
    carry_d = carry_q;
    z_d     = z_q;
    step_d  = step_q;
    flag_d  = flag_q;
    done_d  = 1'b0;

    // External write first, so a flag-setting completion below overrides it.
    if (flag_wr) begin
      flag_d = flag_wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          mode_d  = mode_e'(mode);
          setf_d  = set_flags;
          carry_d = (mode_e'(mode) == MODE_CMP);
          z_d     = 1'b1;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum[CHUNK];
        z_d     = z_new;
        step_d  = step_q + 1'b1;
        if (last_step) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (setf_q) begin
            flag_d = {n_new, z_new, c_new, v_new};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_CMP;
      setf_q  <= 1'b0;
      carry_q <= 1'b0;
      z_q     <= 1'b0;
      step_q  <= '0;
      flag_q  <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      setf_q  <= setf_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      step_q  <= step_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign flag_out = flag_q;

`ifdef CMP_COND_EN
  logic fn, fz, fc, fv;

  always_comb begin
    {fn, fz, fc, fv} = flag_q;
    cond_pass = 1'b0;
    case (cond)
      4'h0:    cond_pass = fz;                    // EQ
      4'h1:    cond_pass = ~fz;                   // NE
      4'h2:    cond_pass = fc;                    // CS
      4'h3:    cond_pass = ~fc;                   // CC
      4'h4:    cond_pass = fn;                    // MI
      4'h5:    cond_pass = ~fn;                   // PL
      4'h6:    cond_pass = fv;                    // VS
      4'h7:    cond_pass = ~fv;                   // VC
      4'h8:    cond_pass = fc & ~fz;              // HI
      4'h9:    cond_pass = ~fc | fz;              // LS
      4'hA:    cond_pass = (fn == fv);            // GE
      4'hB:    cond_pass = (fn != fv);            // LT
      4'hC:    cond_pass = ~fz & (fn == fv);      // GT
      4'hD:    cond_pass = fz | (fn != fv);       // LE
      default: cond_pass = 1'b1;                  // AL (14 and 15)
    endcase
  end
`endif

endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb/tb_cmp_flag_unit.sv - randomized self-checking bench for cmp_flag_unit against an arithmetic flag model

module tb_cmp_flag_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int STEPS = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             set_flags;
  logic             flag_wr;
  logic [3:0]       flag_wdata;
  logic [3:0]       flag_out;
  logic             done;
  logic             busy;
`ifdef CMP_COND_EN
  logic [3:0]       cond;
  logic [0:0]       cond_pass;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_flags;

  cmp_flag_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mode       (mode),
    .set_flags  (set_flags),
    .flag_wr    (flag_wr),
    .flag_wdata (flag_wdata),
    .flag_out   (flag_out),
    .done       (done),
    .busy       (busy)
`ifdef CMP_COND_EN
    ,
    .cond       (cond),
    .cond_pass  (cond_pass)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference flags from whole-word arithmetic: V is set when the exact
  // signed result does not fit in WIDTH bits.
  function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] m, input logic [3:0] prior);
    logic [32:0] wide;
    logic [31:0] r;
    longint      exact;
    logic        c, v;
    c = prior[1];
    v = prior[0];
    r = '0;
    case (m)
      2'd0: begin
        r     = a - b;
        c     = (a >= b);
        exact = longint'($signed(a)) - longint'($signed(b));
        v     = (exact != longint'($signed(r)));
      end
      2'd1: begin
        wide  = {1'b0, a} + {1'b0, b};
        r     = wide[31:0];
        c     = wide[32];
        exact = longint'($signed(a)) + longint'($signed(b));
        v     = (exact != longint'($signed(r)));
      end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic cond_model(input logic [3:0] f, input logic [3:0] code);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request (assumes caller is 1 time unit after a rising edge)
  // and follow it through RUN to its completion cycle. wr_cyc selects the
  // RUN cycle in which flag_wr is driven (-1 for none); noise scrambles all
  // request inputs and holds in_valid during RUN.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic s, input int wr_cyc, input logic [3:0] wd, input bit noise);
    logic [3:0] prior;
    check("ready_before_issue", in_ready, 1);
    op_a      = a;
    op_b      = b;
    mode      = m;
    set_flags = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    prior    = exp_flags;
    for (int i = 0; i < STEPS; i++) begin
      check("busy_in_run", busy, 1);
      check("no_done_in_run", done, 0);
      check("not_ready_in_run", in_ready, 0);
      if (noise) begin
        op_a      = $urandom;
        op_b      = $urandom;
        mode      = 2'($urandom);
        set_flags = 1'($urandom);
        in_valid  = 1'b1;
      end
      flag_wr    = (i == wr_cyc);
      flag_wdata = wd;
      if (i == wr_cyc && i < STEPS - 1) prior = wd;
      @(posedge clk); #1;
    end
    flag_wr  = 1'b0;
    in_valid = 1'b0;
    if (s)               exp_flags = model(a, b, m, prior);
    else if (wr_cyc >= 0) exp_flags = wd;
    else                 exp_flags = prior;
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    check("ready_with_done", in_ready, 1);
    check("flags_on_done", flag_out, exp_flags);
  endtask

  task automatic write_flags(input logic [3:0] w);
    flag_wr    = 1'b1;
    flag_wdata = w;
    @(posedge clk); #1;
    flag_wr   = 1'b0;
    exp_flags = w;
    check("flag_wr_value", flag_out, w);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_single_cycle", done, 0);
    check("idle_ready", in_ready, 1);
  endtask

`ifdef CMP_COND_EN
  task automatic cond_check(input logic [3:0] code, input logic expect_v);
    cond = code;
    #1;
    check("cond_pass", cond_pass, expect_v);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    op_a       = '0;
    op_b       = '0;
    mode       = 2'd0;
    set_flags  = 1'b0;
    flag_wr    = 1'b0;
    flag_wdata = 4'b0;
    exp_flags  = 4'b0000;
`ifdef CMP_COND_EN
    cond = 4'hE;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", flag_out, 4'b0000);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(32'd5, 32'd3, 2'd0, 1'b1, -1, 4'h0, 1'b0);
    check("cmp_5_3", flag_out, 4'b0010);
`ifdef CMP_COND_EN
    cond_check(4'hC, 1'b1);
    cond_check(4'hD, 1'b0);
`endif
    idle_cycle();
    issue(32'd3, 32'd5, 2'd0, 1'b1, -1, 4'h0, 1'b0);
    check("cmp_3_5", flag_out, 4'b1000);
    issue(32'd7, 32'd7, 2'd0, 1'b1, -1, 4'h0, 1'b0);
    check("cmp_7_7", flag_out, 4'b0110);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b1, -1, 4'h0, 1'b0);
    check("cmp_overflow", flag_out, 4'b1001);
`ifdef CMP_COND_EN
    cond_check(4'h6, 1'b1);
    cond_check(4'hA, 1'b1);
`endif
    issue(32'hFFFF_FFFF, 32'd1, 2'd1, 1'b1, -1, 4'h0, 1'b0);
    check("cmn_wrap", flag_out, 4'b0110);
    idle_cycle();

    write_flags(4'b0011);
    issue(32'hF0, 32'h0F, 2'd2, 1'b1, -1, 4'h0, 1'b0);
    check("tst_keeps_cv", flag_out, 4'b0111);
    issue(32'h1234, 32'h1234, 2'd3, 1'b0, -1, 4'h0, 1'b0);
    check("teq_no_set", flag_out, 4'b0111);
    issue(32'h1, 32'h1, 2'd2, 1'b1, STEPS - 1, 4'b1010, 1'b0);
    check("completion_beats_wr", flag_out, 4'b0011);
    idle_cycle();

    // Reset two cycles into RUN
    op_a      = 32'd9;
    op_b      = 32'd2;
    mode      = 2'd0;
    set_flags = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    exp_flags = 4'b0000;
    check("abort_flags", flag_out, 4'b0000);
    check("abort_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < STEPS + 2; i++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", done, 0);
      check("no_busy_after_abort", busy, 0);
    end

    // Request with in_valid held and inputs scrambled during RUN
    issue(32'd100, 32'd200, 2'd0, 1'b1, -1, 4'h0, 1'b1);
    idle_cycle();
    check("no_second_busy", busy, 0);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a, b;
      logic [1:0]  m;
      logic        s;
      int          wr_cyc;
      int          gap;
      a = pick_operand();
      b = ($urandom_range(0, 5) == 0) ? a : pick_operand();
      m = 2'($urandom);
      s = ($urandom_range(0, 3) != 0);
      wr_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, STEPS - 1)) : -1;
      issue(a, b, m, s, wr_cyc, 4'($urandom), 1'($urandom));
`ifdef CMP_COND_EN
      begin
        logic [3:0] code;
        code = 4'($urandom);
        cond_check(code, cond_model(exp_flags, code));
      end
`endif
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      if ($urandom_range(0, 9) == 0) write_flags(4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_flag_unit.md
Name: cmp_flag_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle compare block.
- Evaluates CMP (subtract), CMN (add), TST (AND) or TEQ (XOR) on two WIDTH-bit operands, CHUNK bits per cycle.
- Owns the architectural NZCV flag register and updates it only when set_flags is high.
- Sits beside the ALU in the execute stage. The core issues compares through a valid/ready handshake.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle.
- STEPS, WIDTH/CHUNK: derived. Do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- op_a  in  WIDTH  first operand
- op_b  in  WIDTH  second operand
- mode  in  2  0=CMP(a-b), 1=CMN(a+b), 2=TST(a&b), 3=TEQ(a^b)
- set_flags  in  1  write flags on completion
- flag_wr  in  1  external flag write (MSR path)
- flag_wdata  in  4  external flag value {N,Z,C,V}
- flag_out  out  4  flag register {N,Z,C,V}
- done  out  1  one-cycle completion pulse
- busy  out  1  high in RUN

Behaviour:
- Reset (async, rst_n=0):
  - flag_out=4'b0000, done=0, busy=0, in_ready=1, state=IDLE.
  - All operand, carry and Z accumulators cleared.
- States: IDLE, RUN.
- Accept:
  - A request is accepted on the edge where in_valid && in_ready.
  - op_a, op_b, mode and set_flags are captured at that edge. Step counter=0. Go to RUN.
- RUN, one chunk per cycle, LSB chunk first:
  - CMP: a + ~b + carry, with initial carry-in 1.
  - CMN: a + b, with initial carry-in 0.
  - TST/TEQ: bitwise operation, no carry.
  - Carry propagates between chunks in a register.
  - Z accumulates as the AND of "chunk==0" across all chunks.
- Completion:
  - After STEPS RUN cycles the block returns to IDLE.
  - done pulses high for exactly one cycle on the edge that leaves RUN.
  - Accept at edge T gives done high and flag_out updated after edge T+STEPS.
  - in_ready returns high in the same cycle done is high.
  - Back-to-back issue: the next request is accepted while done is high, giving a throughput of one compare per STEPS+1 cycles.
- Flag rules (applied only if set_flags was 1):
  - N = result[WIDTH-1].
  - Z = full result is zero.
  - CMP:
    - C = 1 when no borrow (a >= b unsigned).
    - V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - CMN:
    - C = carry out of bit WIDTH-1.
    - V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - TST/TEQ: C and V hold their prior values.
  - set_flags=0: flag_out unchanged, but done still pulses.
- flag_wr:
  - When high, flag_out <= flag_wdata on the next edge.
  - If flag_wr coincides with a completion that has set_flags=1, the completion wins and flag_wdata is dropped.
- Hazards and protocol rules:
  - in_valid while busy is ignored. No queueing.
  - Inputs changing during RUN have no effect.
- Reset asserted mid-RUN:
  - Aborts immediately and forces the reset values.
  - No done pulse; flags return to 0000.

Optional Feature:
- Macro: CMP_COND_EN.
- Defined:
  - Adds input cond[3:0] and output cond_pass[0:0].
  - cond_pass is combinational from flag_out using the standard 16-code condition table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, and code 15 = AL.
  - When done is high, cond_pass already reflects the updated flags, since flag_out was registered at that edge.
- Undefined: neither port exists and no condition logic is synthesised.

Test Plan (WIDTH=32, CHUNK=8, STEPS=4):
1. CMP a=5, b=3, S=1 at edge T -> busy for 4 cycles; done after T+4; flag_out=4'b0010.
2. CMP a=3, b=5, S=1 -> flag_out=4'b1000. Then CMP a=7, b=7 -> flag_out=4'b0110.
3. CMP a=32'h7FFFFFFF, b=32'hFFFFFFFF -> result 32'h80000000, flag_out=4'b1001. Then CMN a=32'hFFFFFFFF, b=1 -> flag_out=4'b0110.
4. Preload flag_out=4'b0011 via flag_wr, then:
   - TST a=32'hF0, b=32'h0F, S=1 -> flag_out=4'b0111.
   - TEQ with S=0 -> done pulses, flag_out stays 4'b0111.
   - flag_wr together with a completion -> completion value wins.
5. Reset mid-op: assert rst_n=0 two cycles into RUN -> no done pulse, flag_out=0000, in_ready=1. Hold in_valid during RUN -> ignored, no second done.
6. With CMP_COND_EN: after case 1, cond=GT (4'hC) -> cond_pass=1, cond=LE -> 0. After case 3 (first compare), cond=VS -> 1 and cond=GE -> 1.
